// File: rtl/pin_verifier.sv
// PIN entry and check after card insertion: collects BCD digits,
// compares against the stored password, limits attempts and ejects on idle.
module pin_verifier #(
   parameter int password_width = 16,
   parameter int digit_width    = 4,
   parameter int max_tries      = 3,
   parameter int timeout_cycles = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      psw_en,
   input  logic [password_width-1:0] password,
   input  logic                      digit_valid,
   input  logic [digit_width-1:0]    digit,
   input  logic                      clear_entry,
   input  logic                      cancel,
   output logic                      auth_ok,
   output logic                      pin_wrong,
   output logic                      card_lock,
   output logic                      locked,
   output logic                      eject_req,
   output logic                      digit_err,
   output logic [2:0]                tries_left,
   output logic [2:0]                digit_cnt
);

   localparam int NDIG = password_width / digit_width;
   localparam int TW = $clog2(timeout_cycles);
   localparam logic [TW-1:0] T_LAST = TW'(timeout_cycles - 1);

   typedef enum logic [2:0] {
      IDLE, COLLECT, CHECK, AUTH, LOCKED
   } state_t;

   state_t                    state, state_n;
   logic [password_width-1:0] entry, entry_n;
   logic [TW-1:0]             timer, timer_n, timer_inc;
   logic [2:0]                tries_n, cnt_n;
   logic                      auth_d, pw_d, lock_d, locked_d;
   logic                      eject_d, derr_d;
   logic                      bad_digit, mismatch, time_up;

   assign timer_inc = (timer == T_LAST) ? timer : timer + 1'b1;
   assign time_up   = (timer_inc == T_LAST);
   assign bad_digit = (digit > digit_width'(9));
   assign mismatch  = (entry != password);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         entry      <= '0;
         timer      <= '0;
         tries_left <= '0;
         digit_cnt  <= '0;
         auth_ok    <= 1'b0;
         pin_wrong  <= 1'b0;
         card_lock  <= 1'b0;
         locked     <= 1'b0;
         eject_req  <= 1'b0;
         digit_err  <= 1'b0;
      end else begin
         state      <= state_n;
         entry      <= entry_n;
         timer      <= timer_n;
         tries_left <= tries_n;
         digit_cnt  <= cnt_n;
         auth_ok    <= auth_d;
         pin_wrong  <= pw_d;
         card_lock  <= lock_d;
         locked     <= locked_d;
         eject_req  <= eject_d;
         digit_err  <= derr_d;
      end
   end

   always_comb begin
      state_n = state;
      entry_n = entry;
      timer_n = timer;
      tries_n = tries_left;
      cnt_n   = digit_cnt;
      if (!psw_en) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               state_n = COLLECT;
               tries_n = 3'(max_tries);
               cnt_n   = '0;
               timer_n = '0;
               entry_n = '0;
            end
            COLLECT: begin
               if (cancel) begin
                  state_n = IDLE;
               end else if (clear_entry) begin
                  cnt_n   = '0;
                  entry_n = '0;
                  timer_n = '0;
               end else if (digit_valid) begin
                  timer_n = '0;
                  if (!bad_digit) begin
                     entry_n = {entry[password_width-digit_width-1:0], digit};
                     cnt_n   = digit_cnt + 3'd1;
                     if (digit_cnt == 3'(NDIG - 1))
                        state_n = CHECK;
                  end
               end else if (time_up) begin
                  state_n = IDLE;
               end else begin
                  timer_n = timer_inc;
               end
            end
            CHECK: begin
               if (cancel) begin
                  state_n = IDLE;
               end else if (!mismatch) begin
                  state_n = AUTH;
               end else if (tries_left > 3'd1) begin
                  state_n = COLLECT;
                  tries_n = tries_left - 3'd1;
                  cnt_n   = '0;
                  entry_n = '0;
                  timer_n = '0;
               end else begin
                  state_n = LOCKED;
                  tries_n = '0;
               end
            end
            AUTH: begin
               if (cancel)
                  state_n = IDLE;
            end
            LOCKED: state_n = LOCKED;
            default: state_n = IDLE;
         endcase
      end
   end

   // pulses are decoded from the same priority chain as the next state
   always_comb begin
      auth_d   = (state_n == AUTH);
      locked_d = (state_n == LOCKED);
      eject_d  = 1'b0;
      derr_d   = 1'b0;
      pw_d     = 1'b0;
      lock_d   = 1'b0;
      if (psw_en) begin
         if (cancel) begin
            eject_d = (state == COLLECT) || (state == CHECK) || (state == AUTH);
         end else if (state == COLLECT) begin
            if (!clear_entry) begin
               derr_d  = digit_valid && bad_digit;
               eject_d = !digit_valid && time_up;
            end
         end else if (state == CHECK && mismatch) begin
            pw_d   = (tries_left > 3'd1);
            lock_d = (tries_left <= 3'd1);
         end
      end
   end

endmodule
